// File: rtl/board_sequencer.sv
// Board/room controller: owns the active board index, sequences the fade-out/swap/fade-in
// transition when the leading player leaves the screen, and detects the win at either end board.
module board_sequencer #(
    parameter int unsigned NUM_BOARDS  = 5,
    parameter int unsigned START_BOARD = 3,
    parameter int unsigned EDGE_LEFT   = 10,
    parameter int unsigned EDGE_RIGHT  = 1014,
    parameter int unsigned FADE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        start,
    input  logic [1:0]  leader,
    input  logic [11:0] xpos_playerL,
    input  logic [11:0] xpos_playerR,
    output logic [2:0]  board_out,
    output logic [3:0]  fade_level,
    output logic        freeze,
    output logic        respawn_req,
    output logic [1:0]  winner,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StFadeOut,
        StSwap,
        StFadeIn,
        StWin
    } state_e;

    localparam logic [2:0]  FirstBoard = 3'd1;
    localparam logic [2:0]  LastBoard  = 3'(NUM_BOARDS);
    localparam logic [2:0]  StartBoard = 3'(START_BOARD);
    localparam logic [3:0]  FadeMax    = 4'(FADE_FRAMES);
    localparam logic [11:0] EdgeL      = 12'(EDGE_LEFT);
    localparam logic [11:0] EdgeR      = 12'(EDGE_RIGHT);

    state_e state_q;
    logic   vsync_q;
    logic   dir_down_q;
    logic   tick;
    logic   exit_right;
    logic   exit_left;

    assign tick = vsync_in & ~vsync_q;

    // Only the player holding right of way can trigger an exit, and only on a frame tick.
    assign exit_right = tick && (leader == 2'b01) && (xpos_playerL >= EdgeR);
    assign exit_left  = tick && (leader == 2'b10) && (xpos_playerR < EdgeL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            vsync_q     <= 1'b0;
            dir_down_q  <= 1'b0;
            board_out   <= StartBoard;
            fade_level  <= 4'd0;
            freeze      <= 1'b1;
            respawn_req <= 1'b0;
            winner      <= 2'b00;
            game_over   <= 1'b0;
        end else begin
            vsync_q     <= vsync_in;
            respawn_req <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StPlay;
                        board_out   <= StartBoard;
                        freeze      <= 1'b0;
                        respawn_req <= 1'b1;
                    end
                end
                StPlay: begin
                    if (exit_right) begin
                        freeze <= 1'b1;
                        if (board_out == LastBoard) begin
                            state_q   <= StWin;
                            winner    <= 2'b01;
                            game_over <= 1'b1;
                        end else begin
                            state_q    <= StFadeOut;
                            dir_down_q <= 1'b0;
                        end
                    end else if (exit_left) begin
                        freeze <= 1'b1;
                        if (board_out == FirstBoard) begin
                            state_q   <= StWin;
                            winner    <= 2'b10;
                            game_over <= 1'b1;
                        end else begin
                            state_q    <= StFadeOut;
                            dir_down_q <= 1'b1;
                        end
                    end
                end
                StFadeOut: begin
                    // The new board and the respawn pulse become visible together in the swap clk.
                    if (fade_level == FadeMax) begin
                        state_q     <= StSwap;
                        board_out   <= dir_down_q ? board_out - 3'd1 : board_out + 3'd1;
                        respawn_req <= 1'b1;
                    end else if (tick) begin
                        fade_level <= fade_level + 4'd1;
                    end
                end
                StSwap: begin
                    state_q <= StFadeIn;
                end
                StFadeIn: begin
                    if (fade_level == 4'd0) begin
                        state_q <= StPlay;
                        freeze  <= 1'b0;
                    end else if (tick) begin
                        fade_level <= fade_level - 4'd1;
                    end
                end
                StWin: begin
                    if (start) begin
                        state_q     <= StPlay;
                        board_out   <= StartBoard;
                        winner      <= 2'b00;
                        game_over   <= 1'b0;
                        freeze      <= 1'b0;
                        respawn_req <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_sequencer.sv
// Directed bench for board_sequencer: a behavioural model checked every cycle plus
// hand-computed literal expectations at the key points of each scenario.
module tb_board_sequencer;

    localparam int NB = 5;
    localparam int SB = 3;
    localparam int EL = 10;
    localparam int ER = 1014;
    localparam int FF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  leader = 2'b00;
    logic [11:0] xpos_playerL = 12'd500;
    logic [11:0] xpos_playerR = 12'd500;
    logic [2:0]  board_out;
    logic [3:0]  fade_level;
    logic        freeze;
    logic        respawn_req;
    logic [1:0]  winner;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;
    int resp_count = 0;

    always #5 clk = ~clk;

    board_sequencer #(
        .NUM_BOARDS (NB),
        .START_BOARD(SB),
        .EDGE_LEFT  (EL),
        .EDGE_RIGHT (ER),
        .FADE_FRAMES(FF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync_in    (vsync_in),
        .start       (start),
        .leader      (leader),
        .xpos_playerL(xpos_playerL),
        .xpos_playerR(xpos_playerR),
        .board_out   (board_out),
        .fade_level  (fade_level),
        .freeze      (freeze),
        .respawn_req (respawn_req),
        .winner      (winner),
        .game_over   (game_over)
    );

    // Model: m_run = game in progress, m_over = won; m_half tracks transition progress
    // (0 none, 1 darkening, 2 swap clk, 3 brightening).
    bit         m_vq = 1'b0;
    bit         m_run = 1'b0;
    bit         m_over = 1'b0;
    bit         m_resp = 1'b0;
    int         m_half = 0;
    int         m_fade = 0;
    int         m_board = SB;
    int         m_step = 0;
    logic [1:0] m_win = 2'b00;
    wire        m_tick = vsync_in && !m_vq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_vq <= 1'b0; m_run <= 1'b0; m_over <= 1'b0; m_resp <= 1'b0;
            m_half <= 0; m_fade <= 0; m_board <= SB; m_step <= 0; m_win <= 2'b00;
        end else begin
            m_vq   <= vsync_in;
            m_resp <= 1'b0;
            if (!m_run) begin
                if (start) begin
                    m_run <= 1'b1; m_over <= 1'b0; m_win <= 2'b00;
                    m_board <= SB; m_resp <= 1'b1;
                end
            end else if (m_half == 0) begin
                if (m_tick && leader == 2'b01 && int'(xpos_playerL) >= ER) begin
                    if (m_board == NB) begin
                        m_run <= 1'b0; m_over <= 1'b1; m_win <= 2'b01;
                    end else begin
                        m_half <= 1; m_step <= 1;
                    end
                end else if (m_tick && leader == 2'b10 && int'(xpos_playerR) < EL) begin
                    if (m_board == 1) begin
                        m_run <= 1'b0; m_over <= 1'b1; m_win <= 2'b10;
                    end else begin
                        m_half <= 1; m_step <= -1;
                    end
                end
            end else if (m_half == 1) begin
                if (m_fade == FF) begin
                    m_half <= 2; m_board <= m_board + m_step; m_resp <= 1'b1;
                end else if (m_tick) begin
                    m_fade <= m_fade + 1;
                end
            end else if (m_half == 2) begin
                m_half <= 3;
            end else begin
                if (m_fade == 0) m_half <= 0;
                else if (m_tick) m_fade <= m_fade - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_freeze;
        exp_freeze = !m_run || (m_half != 0);
        n_cmp++;
        if ({board_out, fade_level, freeze, respawn_req, winner, game_over} !==
            {3'(m_board), 4'(m_fade), exp_freeze, m_resp, m_win, m_over}) begin
            n_bad++;
            $display("FAIL cycle_compare t=%0t board %0d want %0d fade %0d want %0d freeze %b want %b resp %b want %b winner %b want %b over %b want %b",
                     $time, board_out, m_board, fade_level, m_fade, freeze, exp_freeze,
                     respawn_req, m_resp, winner, m_win, game_over, m_over);
        end
        if (respawn_req === 1'b1) resp_count++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One frame: vsync high for 2 clks, low for 3; the tick lands on the first posedge.
    task automatic frame();
        vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic move(input logic [1:0] who, input int exp_board);
        int r0;
        leader = who;
        if (who == 2'b01) xpos_playerL = 12'(ER);
        else xpos_playerR = 12'(EL - 1);
        frame();
        xpos_playerL = 12'd500;
        xpos_playerR = 12'd500;
        check("exit_freeze", int'(freeze), 1);
        r0 = resp_count;
        for (int i = 1; i <= FF; i++) begin
            frame();
            check("fade_out_level", int'(fade_level), i);
        end
        check("swap_board", int'(board_out), exp_board);
        check("swap_resp_pulses", resp_count - r0, 1);
        for (int i = FF - 1; i >= 0; i--) begin
            frame();
            check("fade_in_level", int'(fade_level), i);
        end
        check("back_to_play_freeze", int'(freeze), 0);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        check("reset_board", int'(board_out), SB);
        check("reset_fade", int'(fade_level), 0);
        check("reset_freeze", int'(freeze), 1);
        check("reset_winner", int'(winner), 0);
        reset = 1'b0;
        @(negedge clk);

        pulse_start();
        check("start_board", int'(board_out), 3);
        check("start_resp_high", int'(respawn_req), 1);
        check("start_freeze_low", int'(freeze), 0);
        @(negedge clk);
        check("start_resp_once", int'(respawn_req), 0);

        move(2'b01, 4);
        move(2'b10, 3);
        move(2'b10, 2);
        move(2'b10, 1);

        leader = 2'b10;
        xpos_playerR = 12'd9;
        frame();
        xpos_playerR = 12'd500;
        check("left_win_winner", int'(winner), 2);
        check("left_win_over", int'(game_over), 1);
        check("left_win_freeze", int'(freeze), 1);
        check("left_win_board", int'(board_out), 1);
        frame();
        check("win_hold_fade", int'(fade_level), 0);

        pulse_start();
        check("restart_board", int'(board_out), 3);
        check("restart_winner", int'(winner), 0);
        check("restart_over", int'(game_over), 0);

        leader = 2'b10;
        xpos_playerL = 12'd1020;
        frame();
        check("non_leader_edge", int'(freeze), 0);
        leader = 2'b11;
        xpos_playerR = 12'd0;
        frame();
        check("no_leader_edge", int'(freeze), 0);
        leader = 2'b10;
        xpos_playerL = 12'd500;
        xpos_playerR = 12'(EL);
        frame();
        check("strict_left_edge", int'(freeze), 0);
        xpos_playerR = 12'd500;

        leader = 2'b01;
        xpos_playerL = 12'd1020;
        repeat (2) @(negedge clk);
        xpos_playerL = 12'd500;
        frame();
        check("between_ticks_ignored", int'(freeze), 0);
        check("between_ticks_fade", int'(fade_level), 0);

        move(2'b01, 4);
        move(2'b01, 5);
        leader = 2'b01;
        xpos_playerL = 12'(ER);
        frame();
        xpos_playerL = 12'd500;
        check("right_win_winner", int'(winner), 1);
        check("right_win_board", int'(board_out), 5);
        check("right_win_over", int'(game_over), 1);

        pulse_start();
        check("restart2_board", int'(board_out), 3);
        leader = 2'b10;
        xpos_playerR = 12'd9;
        frame();
        xpos_playerR = 12'd500;
        repeat (5) frame();
        check("mid_fade_level", int'(fade_level), 5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_board", int'(board_out), 3);
        check("async_reset_fade", int'(fade_level), 0);
        check("async_reset_freeze", int'(freeze), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        pulse_start();
        r0 = resp_count;
        leader = 2'b01;
        xpos_playerL = 12'(ER);
        frame();
        xpos_playerL = 12'd500;
        repeat (FF + 3) frame();
        check("fade_in_before_start", int'(fade_level), FF - 3);
        pulse_start();
        repeat (FF - 3) frame();
        check("start_in_fade_board", int'(board_out), 4);
        check("start_in_fade_level", int'(fade_level), 0);
        check("start_in_fade_freeze", int'(freeze), 0);
        check("start_in_fade_resp", resp_count - r0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_sequencer.md
Name: board_sequencer

Overview:
- Room/board controller for the arena renderer chain.
- Owns the active board index (1..NUM_BOARDS) that selects the background scene drawn per frame.
- Advances or retreats the board when the player holding right of way exits the screen edge, and runs a frame-counted fade-out/swap/fade-in transition.
- Detects the win at either end board and freezes play during transitions and after a win.

Parameters:
NUM_BOARDS, 5, number of boards; valid board indices 1..NUM_BOARDS
START_BOARD, 3, board loaded at reset and at every game (re)start
EDGE_LEFT, 10, player R exits left when xpos_playerR < EDGE_LEFT
EDGE_RIGHT, 1014, player L exits right when xpos_playerL >= EDGE_RIGHT
FADE_FRAMES, 8, frames per fade half; range 1..15

Ports:
clk  in  1  pixel clock
reset  in  1  reset, asynchronous, active-high
vsync_in  in  1  vertical sync from timing chain; rising edge = frame tick
start  in  1  one-cycle start/restart request
leader  in  2  right of way: 01 = player L (moves right), 10 = player R (moves left), 00/11 = none
xpos_playerL  in  12  player L x position
xpos_playerR  in  12  player R x position
board_out  out  3  active board index to renderer
fade_level  out  4  0 = full brightness, FADE_FRAMES = black
freeze  out  1  high = player controllers hold position/inputs
respawn_req  out  1  one-cycle pulse: players reload spawn positions
winner  out  2  01 = L won, 10 = R won, 00 = none
game_over  out  1  high in WIN state

Behaviour:
- Reset values: state IDLE, board_out=START_BOARD, fade_level=0, freeze=1, respawn_req=0, winner=00, game_over=0. The vsync edge-detect register resets to 0.
- Frame tick: vsync_in registered once; tick = vsync_in & ~vsync_q. Tick is asserted for exactly one clk per frame.
- Position and leader sampling happens only on clocks where tick=1. Changes between ticks are ignored.
- IDLE:
  - freeze=1.
  - start=1 -> PLAY; board_out=START_BOARD; respawn_req pulses once on the same transition.
- PLAY:
  - freeze=0.
  - On tick with leader==01 and xpos_playerL >= EDGE_RIGHT:
    - if board_out==NUM_BOARDS -> WIN, winner=01;
    - else -> FADE_OUT with dir=+1.
  - On tick with leader==10 and xpos_playerR < EDGE_LEFT:
    - if board_out==1 -> WIN, winner=10;
    - else -> FADE_OUT with dir=-1.
  - leader 00/11: no exit is possible, even when both positions are past their edges.
  - Only the leader's own edge is evaluated. The non-leader crossing any edge has no effect.
- FADE_OUT:
  - freeze=1.
  - Each tick: fade_level += 1.
  - The clk after fade_level reaches FADE_FRAMES -> SWAP.
- SWAP (one clk):
  - board_out <= board_out + dir, computed 3-bit unsigned. The result is always within 1..NUM_BOARDS because the end boards route to WIN.
  - respawn_req=1 for this clk only.
  - Next -> FADE_IN.
- FADE_IN:
  - freeze=1.
  - Each tick: fade_level -= 1.
  - The clk after fade_level reaches 0 -> PLAY.
- WIN:
  - freeze=1, game_over=1, fade_level holds at 0, board_out holds.
  - start=1 -> PLAY: board_out=START_BOARD, winner=00, game_over=0, respawn_req pulses.
- Latency:
  - Exit condition sampled on tick clk N; state changes at clk N+1.
  - Full transition = 2*FADE_FRAMES ticks + 1 SWAP clk (+ the edge-detect clks).
- start asserted outside IDLE and WIN is ignored. A leader/position change during FADE_OUT, SWAP or FADE_IN is ignored.
- Asynchronous reset mid-transition returns to IDLE with the reset values immediately. The board does not keep the in-flight increment.
- fade_level never wraps: it saturates at FADE_FRAMES in FADE_OUT and at 0 in FADE_IN.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset, then start pulse -> board_out=3; respawn_req high exactly 1 clk; freeze 1->0.
- PLAY, leader=01, xpos_playerL=1014, then tick -> FADE_OUT:
  - fade_level steps 1..8 over 8 ticks;
  - SWAP gives board_out=4 with one respawn_req pulse;
  - fade_level steps back to 0 over 8 ticks;
  - freeze=0 afterwards.
- board_out=1, leader=10, xpos_playerR=9, tick -> WIN: winner=10, game_over=1, freeze=1. Then start -> board_out=3, winner=00.
- Edge cases, one per tick:
  - leader=10 with xpos_playerL=1020 -> no transition (non-leader edge).
  - leader=11 with both players past edges -> no transition.
  - xpos_playerR=10 with leader=10 -> no transition (strict < EDGE_LEFT).
- Positions cross the edge and return between two ticks -> no transition. Reset asserted mid-FADE_OUT with fade_level=5 -> IDLE immediately, board_out=3, fade_level=0.
- Board 5, leader=01, xpos_playerL=1014, tick -> WIN, winner=01, board_out stays 5. A start pulse during FADE_IN (separate run) is ignored.
